// File: rtl/regfile_dump_if.sv
// Port bundle for regfile_dump: register-file read port A, the streamed word
// handshake, and the start/busy/done control strobes.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] busa;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, busa, dout_ready,
    output ra, dout, dout_valid, busy, done
  );

  modport slave (
    output start, busa, dout_ready,
    input  ra, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks register-file read port A from r0 to r(NUM_REGS-1) and streams each word
// over valid/ready. Optional trailing XOR checksum word: REGFILE_DUMP_CKSUM_EN.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic           clk,
  input logic           reset,
  regfile_dump_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef REGFILE_DUMP_CKSUM_EN
    CKSUM,
`endif
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
`ifdef REGFILE_DUMP_CKSUM_EN
  logic [DATA_W-1:0] cksum;
`endif

  // idx doubles as the registered read address; it is parked at 0 outside a dump
  assign bus.ra         = idx;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FINISH);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.start) next_state = FETCH;
      FETCH:  next_state = SEND;
      SEND: begin
        if (bus.dout_ready) begin
          if (idx == LAST) begin
`ifdef REGFILE_DUMP_CKSUM_EN
            next_state = CKSUM;
`else
            next_state = FINISH;
`endif
          end else begin
            next_state = FETCH;
          end
        end
      end
`ifdef REGFILE_DUMP_CKSUM_EN
      CKSUM:  if (bus.dout_ready) next_state = FINISH;
`endif
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
      cksum   <= '0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx <= '0;
`ifdef REGFILE_DUMP_CKSUM_EN
            cksum <= '0;
`endif
          end
        end
        FETCH: begin
          dout_q  <= bus.busa;
          valid_q <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
          cksum   <= cksum ^ bus.busa;
`endif
        end
        SEND: begin
          if (bus.dout_ready) begin
            if (idx == LAST) begin
              idx <= '0;
`ifdef REGFILE_DUMP_CKSUM_EN
              // checksum already folds in the final word, so it follows immediately
              dout_q  <= cksum;
              valid_q <= 1'b1;
`else
              valid_q <= 1'b0;
`endif
            end else begin
              idx     <= idx + ADDR_W'(1);
              valid_q <= 1'b0;
            end
          end
        end
`ifdef REGFILE_DUMP_CKSUM_EN
        CKSUM: begin
          if (bus.dout_ready) valid_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump; the expected word stream and
// timing come from a register-array model and closed-form cycle arithmetic.
module tb_regfile_dump;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [DATA_W-1:0] rf [NUM_REGS];

  regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.busa = rf[bus.ra];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] exp_q[$];
  int hs_cyc[$];
  int v_cyc[$];
  int done_cyc[$];
  int hold_err, ra_err, busy_low;
  bit timed_out;
  logic ab_valid, ab_busy, ab_done;
  logic [ADDR_W-1:0] ab_ra;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp;
    logic [DATA_W-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(rf[i]);
      x ^= rf[i];
    end
    if (CK == 1) exp_q.push_back(x);
  endtask

  // Drives one dump and records what the sink observed; rel counts cycles from the start cycle.
  task automatic run_dump(input int rmode, input bit extra, input int abort_word);
    bit hold;
    logic [DATA_W-1:0] pd;
    bit pv;
    got.delete(); hs_cyc.delete(); v_cyc.delete(); done_cyc.delete();
    hold_err = 0; ra_err = 0; busy_low = -1; timed_out = 1'b1;
    hold = 1'b0; pd = '0; pv = 1'b0;
    for (int rel = 0; rel < 600; rel++) begin
      bus.start = (rel == 0) || (extra && (rel == 10 || rel == 30));
      case (rmode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = ((rel % 3) == 2);
        default: bus.dout_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (int'(bus.ra) > NUM_REGS - 1) ra_err++;
      if (hold && (!bus.dout_valid || bus.dout !== pd)) hold_err++;
      if (bus.dout_valid && !pv) v_cyc.push_back(rel);
      if (abort_word >= 0 && bus.dout_valid && got.size() == abort_word) begin
        bus.dout_ready = 1'b0;
        bus.start = 1'b0;
        reset = 1'b1;
        tick;
        ab_valid = bus.dout_valid; ab_busy = bus.busy; ab_ra = bus.ra; ab_done = bus.done;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick;
          if (bus.done) done_cyc.push_back(k);
        end
        timed_out = 1'b0;
        return;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        got.push_back(bus.dout);
        hs_cyc.push_back(rel);
      end
      if (bus.done) done_cyc.push_back(rel);
      if (rel > 0 && !bus.busy && done_cyc.size() > 0) begin
        busy_low = rel;
        timed_out = 1'b0;
        break;
      end
      hold = bus.dout_valid && !bus.dout_ready;
      pd = bus.dout;
      pv = bus.dout_valid;
      tick;
    end
    bus.start = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.dout_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.ra !== '0 || bus.dout !== '0 || bus.dout_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: ra=%0d dout=%h valid=%b busy=%b done=%b, required all 0",
                 c, bus.ra, bus.dout, bus.dout_valid, bus.busy, bus.done);
      end
      tick;
    end
  endtask

  task automatic check_stream(input string name);
    int bad;
    bad = -1;
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL %s timeout: dump did not finish in 600 cycles, required completion", name);
    end
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d, required %0d", name, got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++)
        if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s word[%0d]: got %h, required %h", name, bad, got[bad], exp_q[bad]);
      end
    end
    n_checks++;
    if (done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, done_cyc.size());
    end else if (hs_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc[0] != hs_cyc[hs_cyc.size()-1] + 1) begin
        n_fail++;
        $display("FAIL %s done_after_last: done at %0d, required %0d",
                 name, done_cyc[0], hs_cyc[hs_cyc.size()-1] + 1);
      end
    end
    n_checks++;
    if (hold_err != 0 || ra_err != 0) begin
      n_fail++;
      $display("FAIL %s hold_ra: hold_err=%0d ra_err=%0d, required 0 and 0", name, hold_err, ra_err);
    end
  endtask

  task automatic test_stream_full_rate;
    int bad;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = i * 32'h01010101;
    build_exp;
    run_dump(0, 1'b0, -1);
    check_stream("full_rate");
    bad = -1;
    for (int i = 0; i < NUM_REGS && i < v_cyc.size(); i++)
      if (bad < 0 && v_cyc[i] != 2 + 2*i) bad = i;
    n_checks++;
    if (v_cyc.size() < NUM_REGS || bad >= 0) begin
      n_fail++;
      $display("FAIL valid_timing: %0d valid starts, first bad word %0d, required word i at T+2+2i",
               v_cyc.size(), bad);
    end
    n_checks++;
    if (done_cyc.size() < 1 || done_cyc[0] != 2*NUM_REGS + 1 + CK) begin
      n_fail++;
      $display("FAIL done_timing: done at %0d, required %0d",
               (done_cyc.size() > 0) ? done_cyc[0] : -1, 2*NUM_REGS + 1 + CK);
    end
    n_checks++;
    if (busy_low != 2*NUM_REGS + 2 + CK) begin
      n_fail++;
      $display("FAIL busy_low_timing: busy low at %0d, required %0d", busy_low, 2*NUM_REGS + 2 + CK);
    end
  endtask

  task automatic test_backpressure;
    run_dump(1, 1'b0, -1);
    check_stream("backpressure_001");
    for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
    build_exp;
    run_dump(2, 1'b0, -1);
    check_stream("backpressure_rand");
  endtask

  task automatic test_start_while_busy;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
    build_exp;
    run_dump(0, 1'b1, -1);
    check_stream("start_while_busy");
  endtask

  task automatic test_reset_mid_dump;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = i * 32'h01010101;
    build_exp;
    run_dump(0, 1'b0, 7);
    n_checks++;
    if (ab_valid !== 1'b0 || ab_busy !== 1'b0 || ab_ra !== '0 || ab_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: valid=%b busy=%b ra=%0d done=%b, required 0 0 0 0",
               ab_valid, ab_busy, ab_ra, ab_done);
    end
    n_checks++;
    if (done_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", done_cyc.size());
    end
    run_dump(0, 1'b0, -1);
    check_stream("after_abort");
  endtask

  task automatic test_cksum_patterns;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = i;
    build_exp;
    run_dump(0, 1'b0, -1);
    check_stream("pattern_i");
    for (int i = 0; i < NUM_REGS; i++) rf[i] = i + 1;
    build_exp;
    run_dump(2, 1'b0, -1);
    check_stream("pattern_i_plus_1");
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    test_reset;
    test_stream_full_rate;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_dump;
    test_cksum_patterns;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
